// File: rtl/div_ctrl_if.sv
// Handshake and data bundle between the pipeline and the divide controller.
// The pipeline side is the master; the controller is the slave.
interface div_ctrl_if;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, sign, a, b, flush,
    input  stall, done, hi_out, lo_out
  );

  modport slave (
    input  start, sign, a, b, flush,
    output stall, done, hi_out, lo_out
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit divider controller (DIV / DIVU).
// Restoring radix-2 core on operand magnitudes, sign fix-up applied to the
// final step so HI/LO are loaded on the edge that enters DONE.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; stall follows start & ~flush
//   BUSY  | one restoring step per cycle, 32 steps, stall held high
//   DONE  | result on hi_out/lo_out, stall low; done pulses next cycle
//
// Timing for start sampled at edge k:
//   b != 0 : BUSY after edges k..k+31, DONE after k+32, done after k+33
//   b == 0 : DONE after edge k, done after k+1
module div_ctrl (
  input  logic     clk,
  input  logic     rst,
  div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic        borrow;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Operand magnitudes; unsigned requests pass through untouched.
  always_comb begin
    abs_a = bus.a;
    abs_b = bus.b;
    if (bus.sign && bus.a[31]) abs_a = ~bus.a + 32'd1;
    if (bus.sign && bus.b[31]) abs_b = ~bus.b + 32'd1;
  end

  // One restoring step plus the sign fix-up of its result. The partial
  // remainder stays below the divisor, so the shifted value fits in 33 bits
  // and bit 32 of the trial difference is the borrow.
  always_comb begin
    rem_sh  = {rem, quo[31]};
    trial   = rem_sh - {1'b0, dvs};
    borrow  = trial[32];
    rem_nxt = borrow ? rem_sh[31:0] : trial[31:0];
    quo_nxt = {quo[30:0], ~borrow};
    quo_fix = quo_nxt;
    rem_fix = rem_nxt;
    if (sgn && (a_neg ^ b_neg)) quo_fix = ~quo_nxt + 32'd1;
    if (sgn && a_neg)           rem_fix = ~rem_nxt + 32'd1;
  end

  // Controller FSM with registered done and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      quo    <= 32'd0;
      rem    <= 32'd0;
      dvs    <= 32'd0;
      sgn    <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              sgn   <= bus.sign;
              a_neg <= bus.a[31];
              b_neg <= bus.b[31];
              if (bus.b == 32'd0) begin
                // Divide by zero: fixed result, no iterations.
                hi_q  <= bus.a;
                lo_q  <= 32'hFFFF_FFFF;
                state <= DONE;
              end else begin
                quo   <= abs_a;
                dvs   <= abs_b;
                rem   <= 32'd0;
                cnt   <= 6'd0;
                state <= BUSY;
              end
            end
          end
          BUSY: begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              hi_q  <= rem_fix;
              lo_q  <= quo_fix;
              state <= DONE;
            end
          end
          DONE: begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.stall  = ((state == IDLE) && bus.start && !bus.flush) || (state == BUSY);
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table, random ops against a
// behavioural model, and hand-written flush / reset / held-start sequences.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          due;
  } exp_t;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          stall;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Edge counter: value read after an edge equals the number of edges seen.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every done pulse must match the oldest pending result.
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("lo_out", bus.lo_out, e.lo);
        chk("hi_out", bus.hi_out, e.hi);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  // Issue one divide, count stall-high cycles, wait for the scoreboard.
  task automatic run_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input int estall, input string tag);
    exp_t e;
    int   n;
    int   w;
    bus.sign  = s;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    e.lo  = elo;
    e.hi  = ehi;
    e.due = cyc + 1 + ((bv == 32'd0) ? 1 : 33);
    sb.push_back(e);
    #1;
    n = (bus.stall === 1'b1) ? 1 : 0;
    step();
    bus.start = 1'b0;
    #1;
    while (bus.stall === 1'b1 && n < 100) begin
      n++;
      step();
      #1;
    end
    chk({tag, "_stall_cycles"}, n, estall);
    w = 0;
    while (sb.size() != 0 && w < 60) begin
      step();
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", tag);
      sb.delete();
    end
  endtask

  initial begin : stim
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rlo;
    logic [31:0] rhi;
    int          dc;
    int          w;

    vecs[0]  = '{1'b0, 32'd7,          32'd2,          32'd3,          32'd1,          33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33};
    vecs[3]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vecs[5]  = '{1'b0, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1};
    vecs[6]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[7]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  33};
    vecs[8]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          33};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    vecs[12] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1};

    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.flush = 1'b0;
    rst       = 1'b1;
    step();
    chk("rst_stall",  bus.stall,  32'd0);
    chk("rst_done",   bus.done,   32'd0);
    chk("rst_hi_out", bus.hi_out, 32'd0);
    chk("rst_lo_out", bus.lo_out, 32'd0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi,
             vecs[i].stall, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? $urandom : 32'($urandom_range(1, 300));
      if (rb == 32'd0) rb = 32'd1;
      if (i % 2 == 1) begin
        if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) ra = 32'd1;
        rlo = 32'($signed(ra) / $signed(rb));
        rhi = 32'($signed(ra) % $signed(rb));
      end else begin
        rlo = ra / rb;
        rhi = ra % rb;
      end
      run_op(1'(i % 2), ra, rb, rlo, rhi, 33, $sformatf("rnd%0d", i));
    end

    // Known outputs before the flush sequence: 100/7 -> 14 r 2.
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "pre_flush");
    bus.sign  = 1'b0;
    bus.a     = 32'h1000;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    chk("busy_hold_hi", bus.hi_out, 32'd2);
    chk("busy_hold_lo", bus.lo_out, 32'd14);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1;
    chk("flush_stall",  bus.stall,  32'd0);
    chk("flush_done",   bus.done,   32'd0);
    chk("flush_hold_hi", bus.hi_out, 32'd2);
    chk("flush_hold_lo", bus.lo_out, 32'd14);
    run_op(1'b0, 32'h1000, 32'd3, 32'h555, 32'd1, 33, "after_flush");

    // Flush wins over start in the same cycle.
    dc = done_cnt;
    bus.a     = 32'd5;
    bus.b     = 32'd1;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("flush_start_stall", bus.stall, 32'd0);
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("flush_start_idle", bus.stall, 32'd0);
    repeat (40) step();
    chk("flush_start_no_done", done_cnt - dc, 32'd0);

    // Reset in the middle of BUSY aborts without a done pulse.
    dc = done_cnt;
    bus.a     = 32'h1000;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_hi_out", bus.hi_out, 32'd0);
    chk("midrst_lo_out", bus.lo_out, 32'd0);
    chk("midrst_done",   bus.done,   32'd0);
    chk("midrst_stall",  bus.stall,  32'd0);
    repeat (40) step();
    chk("midrst_no_done", done_cnt - dc, 32'd0);

    // Start held high through BUSY: one accepted op, one done.
    dc = done_cnt;
    begin
      exp_t e;
      bus.sign  = 1'b0;
      bus.a     = 32'd50;
      bus.b     = 32'd5;
      bus.start = 1'b1;
      e.lo  = 32'd10;
      e.hi  = 32'd0;
      e.due = cyc + 34;
      sb.push_back(e);
    end
    repeat (20) step();
    bus.start = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 60) begin
      step();
      w++;
    end
    repeat (40) step();
    chk("held_start_one_done", done_cnt - dc, 32'd1);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench did not finish in time");
  end

endmodule
